// File: rtl/gate_seq_ctrl.sv
// gate_seq_ctrl: Sync/Gate/Done timing sequencer.
// Loads the timing words on an accepted start, then walks the phases
// SYNC -> GDEL -> GATE -> LEN -> DONE -> IDLE and skips any phase of zero length.
// Optional feature macro: GATE_SEQ_REPEAT_EN. It adds the rep_cnt input and runs
// rep_cnt+1 periods back to back, with a single Done after the last period.

module gate_seq_ctrl #(
  parameter int CW = 16,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          start,
  input  logic          abort,
  input  logic [SW-1:0] Tsync,
  input  logic [SW-1:0] Tgdel,
  input  logic [CW-1:0] Tgate,
  input  logic [CW-1:0] Tlen,
`ifdef GATE_SEQ_REPEAT_EN
  input  logic [7:0]    rep_cnt,
`endif
  output logic          Sync,
  output logic          Gate,
  output logic          Done,
  output logic          busy,
  output logic [4:0]    state_o,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] cnt_len_o
);

  localparam int SUMW = CW + 2;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00000,
    S_SYNC = 5'b00001,
    S_GDEL = 5'b00010,
    S_GATE = 5'b00100,
    S_LEN  = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  state_t state;
  state_t next_state;
  state_t end_state;
  state_t after_gate;
  state_t after_gdel;
  state_t after_sync;

  logic [SW-1:0]   tsync_q;
  logic [SW-1:0]   tgdel_q;
  logic [CW-1:0]   tgate_q;
  logic [CW-1:0]   tlen_q;
  logic [SW-1:0]   tsync_eff;
  logic [SUMW-1:0] phase_sum;
  logic            len_en;
  logic            accept;
  logic            phase_exit;
  logic            new_period;

`ifdef GATE_SEQ_REPEAT_EN
  logic [7:0] reps_left;
`endif

  // The counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // A Sync width of 0 behaves as 1. LEN is used only when Tlen is larger than
  // the sum of the active phases. The sum is two bits wider so it cannot overflow.
  assign tsync_eff = (tsync_q == '0) ? SW'(1) : tsync_q;
  assign phase_sum = SUMW'(tsync_eff) + SUMW'(tgdel_q) + SUMW'(tgate_q);
  assign len_en    = SUMW'(tlen_q) > phase_sum;

  // These selects are built from the back of the period forward. A phase of
  // zero length falls through to the next one in the same cycle.
  always_comb begin
`ifdef GATE_SEQ_REPEAT_EN
    end_state = (reps_left != 8'd0) ? S_SYNC : S_DONE;
`else
    end_state = S_DONE;
`endif
    after_gate = len_en ? S_LEN : end_state;
    after_gdel = (tgate_q != '0) ? S_GATE : after_gate;
    after_sync = (tgdel_q != '0) ? S_GDEL : after_gdel;
  end

  // Next-state decode. Each phase ends when its counter reaches the programmed
  // length. While busy, abort overrides every other transition.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    phase_exit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          next_state = S_SYNC;
          accept     = 1'b1;
        end
      end
      S_SYNC: begin
        if (cnt_o == CW'(tsync_eff)) begin
          next_state = after_sync;
          phase_exit = 1'b1;
        end
      end
      S_GDEL: begin
        if (cnt_o == CW'(tgdel_q)) begin
          next_state = after_gdel;
          phase_exit = 1'b1;
        end
      end
      S_GATE: begin
        if (cnt_o == tgate_q) begin
          next_state = after_gate;
          phase_exit = 1'b1;
        end
      end
      S_LEN: begin
        if (cnt_len_o == tlen_q) begin
          next_state = end_state;
          phase_exit = 1'b1;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
        phase_exit = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      next_state = S_IDLE;
    end
    new_period = phase_exit && (next_state == S_SYNC);
  end

  // State, shadow timing, counters and outputs. All of them hold while ena is
  // low. The outputs are decoded from next_state so they line up with state_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tsync_q   <= '0;
      tgdel_q   <= '0;
      tgate_q   <= '0;
      tlen_q    <= '0;
      cnt_o     <= '0;
      cnt_len_o <= '0;
      Sync      <= 1'b0;
      Gate      <= 1'b0;
      Done      <= 1'b0;
      busy      <= 1'b0;
`ifdef GATE_SEQ_REPEAT_EN
      reps_left <= 8'd0;
`endif
    end else if (ena) begin
      state <= next_state;
      Sync  <= (next_state == S_SYNC);
      Gate  <= (next_state == S_GATE);
      Done  <= (next_state == S_DONE);
      busy  <= (next_state != S_IDLE);
      if (accept) begin
        tsync_q <= Tsync;
        tgdel_q <= Tgdel;
        tgate_q <= Tgate;
        tlen_q  <= Tlen;
      end
`ifdef GATE_SEQ_REPEAT_EN
      if (accept) begin
        reps_left <= rep_cnt;
      end else if (new_period) begin
        reps_left <= reps_left - 8'd1;
      end
`endif
      if (next_state == S_IDLE) begin
        cnt_o     <= '0;
        cnt_len_o <= '0;
      end else if (accept || new_period) begin
        cnt_o     <= CW'(1);
        cnt_len_o <= CW'(1);
      end else if (phase_exit) begin
        cnt_o     <= CW'(1);
        cnt_len_o <= sat_inc(cnt_len_o);
      end else begin
        cnt_o     <= sat_inc(cnt_o);
        cnt_len_o <= sat_inc(cnt_len_o);
      end
    end
  end

  assign state_o = state;

endmodule
